// File: rtl/comma_align_deserializer.sv
// Serial-to-parallel converter that recovers 8b/10b word boundaries from comma
// detection, emits aligned words with a one-cycle strobe and reports lock.
module comma_align_deserializer #(
  parameter int               WIDTH      = 10,
  parameter logic [WIDTH-1:0] COMMA      = 10'b0011111010,
  parameter bit               LSB_FIRST  = 1'b1,
  parameter int               LOCK_COUNT = 3,
  parameter int               LOSS_COUNT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             datin,
  input  logic             bit_valid,
  input  logic             realign_en,
  output logic [WIDTH-1:0] datout,
  output logic             dat_valid,
  output logic             is_comma,
  output logic             locked
);

  localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int FW = $clog2(WIDTH + 1);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(LOSS_COUNT + 1);
  localparam logic [PW-1:0] PH_LAST = PW'(WIDTH - 1);

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] window;
  logic [WIDTH-1:0] win_shift;
  logic [PW-1:0]    phase, phase_n;
  logic [FW-1:0]    fill;
  logic [GW-1:0]    good_cnt, good_n;
  logic [BW-1:0]    bad_cnt, bad_n;
  logic             locked_n;
  logic             emit;
  logic             filled;
  logic             hit;
  logic             boundary;

  function automatic logic [FW-1:0] sat_inc(input logic [FW-1:0] v);
    return (v == FW'(WIDTH)) ? v : v + FW'(1);
  endfunction

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
    return r;
  endfunction

  // Newest bit enters at the top so index 0 always holds the oldest bit.
  assign win_shift = {datin, window[WIDTH-1:1]};
  assign filled    = (fill >= FW'(WIDTH - 1));
  assign hit       = bit_valid && filled && ((win_shift == COMMA) || (win_shift == ~COMMA));
  assign boundary  = bit_valid && (phase == PH_LAST);

  always_comb begin
    state_n  = state;
    phase_n  = phase;
    good_n   = good_cnt;
    bad_n    = bad_cnt;
    locked_n = locked;
    emit     = 1'b0;
    if (bit_valid) phase_n = boundary ? '0 : phase + PW'(1);
    case (state)
      HUNT: begin
        if (hit) begin
          phase_n = '0;
          emit    = 1'b1;
          good_n  = GW'(1);
          if (LOCK_COUNT <= 1) begin
            state_n  = LOCKED;
            locked_n = 1'b1;
          end else begin
            state_n = CHECK;
          end
        end
      end
      CHECK: begin
        if (boundary) begin
          emit = 1'b1;
          if (hit) begin
            good_n = good_cnt + GW'(1);
            if (int'(good_cnt) + 1 >= LOCK_COUNT) begin
              state_n  = LOCKED;
              locked_n = 1'b1;
            end
          end
        end else if (hit) begin
          phase_n = '0;
          emit    = 1'b1;
          good_n  = GW'(1);
        end
      end
      LOCKED: begin
        if (boundary) begin
          emit = 1'b1;
          if (hit) bad_n = '0;
        end else if (hit && realign_en) begin
          if (int'(bad_cnt) + 1 >= LOSS_COUNT) begin
            state_n  = CHECK;
            locked_n = 1'b0;
            phase_n  = '0;
            emit     = 1'b1;
            good_n   = GW'(1);
            bad_n    = '0;
          end else begin
            bad_n = bad_cnt + BW'(1);
          end
        end
      end
      default: state_n = HUNT;
    endcase
  end

  // Window contents are ignored until fill reaches WIDTH, so it needs no reset.
  always_ff @(posedge clk) begin
    if (bit_valid) window <= win_shift;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= HUNT;
      phase     <= '0;
      fill      <= '0;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      locked    <= 1'b0;
      dat_valid <= 1'b0;
      is_comma  <= 1'b0;
      datout    <= '0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      good_cnt  <= good_n;
      bad_cnt   <= bad_n;
      locked    <= locked_n;
      dat_valid <= emit;
      if (bit_valid) fill <= sat_inc(fill);
      if (emit) begin
        datout   <= LSB_FIRST ? win_shift : bit_rev(win_shift);
        is_comma <= hit;
      end
    end
  end

endmodule

// File: tb/tb_comma_align_deserializer.sv
// Table-driven, scoreboard-checked bench for comma_align_deserializer, driving an
// LSB-first and an MSB-first instance with the same serial stream.
module tb_comma_align_deserializer;

  localparam logic [9:0] C = 10'b0011111010;
  localparam logic [9:0] N = 10'b1100000101;
  localparam logic [9:0] D = 10'b1010101010;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       datin = 1'b0;
  logic       bit_valid = 1'b0;
  logic       realign_en = 1'b1;
  logic [9:0] do_l, do_m;
  logic       dv_l, dv_m, ic_l, ic_m, lk_l, lk_m;

  comma_align_deserializer #(.WIDTH(10), .COMMA(C), .LSB_FIRST(1'b1),
                             .LOCK_COUNT(3), .LOSS_COUNT(4)) dut (
    .clk(clk), .reset_n(reset_n), .datin(datin), .bit_valid(bit_valid),
    .realign_en(realign_en), .datout(do_l), .dat_valid(dv_l),
    .is_comma(ic_l), .locked(lk_l));

  comma_align_deserializer #(.WIDTH(10), .COMMA(C), .LSB_FIRST(1'b0),
                             .LOCK_COUNT(3), .LOSS_COUNT(4)) dut_msb (
    .clk(clk), .reset_n(reset_n), .datin(datin), .bit_valid(bit_valid),
    .realign_en(realign_en), .datout(do_m), .dat_valid(dv_m),
    .is_comma(ic_m), .locked(lk_m));

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] bits;
    int         nbits;
    bit         emit;
    logic [9:0] dat;
    bit         comma;
    bit         lock;
    int         gap;
  } rec_t;

  typedef struct {
    logic [9:0] dat;
    bit         comma;
    bit         lock;
    int         gap;
  } exp_t;

  rec_t tbl[$];
  exp_t q_lsb[$];
  exp_t q_msb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_l = 0;

  always @(posedge clk) cyc++;

  function automatic logic [9:0] rev10(input logic [9:0] v);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = v[9-i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void add(input logic [9:0] bits, input int nbits, input bit emit,
                              input logic [9:0] dat, input bit comma, input bit lock,
                              input int gap);
    rec_t r;
    r.bits = bits; r.nbits = nbits; r.emit = emit;
    r.dat = dat; r.comma = comma; r.lock = lock; r.gap = gap;
    tbl.push_back(r);
  endfunction

  // LSB-first scoreboard, including word spacing
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && dv_l) begin
      if (q_lsb.size() == 0) begin
        checks++; failures++;
        $display("FAIL lsb_unexpected_word actual=%h required=none", do_l);
      end else begin
        e = q_lsb.pop_front();
        chk("lsb_datout", 32'(do_l), 32'(e.dat));
        chk("lsb_is_comma", 32'(ic_l), 32'(e.comma));
        chk("lsb_locked", 32'(lk_l), 32'(e.lock));
        if (e.gap > 0) chk("lsb_gap", 32'(cyc - last_l), 32'(e.gap));
      end
      last_l = cyc;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset_n && dv_m) begin
      if (q_msb.size() == 0) begin
        checks++; failures++;
        $display("FAIL msb_unexpected_word actual=%h required=none", do_m);
      end else begin
        e = q_msb.pop_front();
        chk("msb_datout", 32'(do_m), 32'(e.dat));
        chk("msb_is_comma", 32'(ic_m), 32'(e.comma));
        chk("msb_locked", 32'(lk_m), 32'(e.lock));
      end
    end
  end

  task automatic send_bit(input logic b, input bit gapped);
    datin = b;
    bit_valid = 1'b1;
    @(posedge clk); #1;
    if (gapped) begin
      bit_valid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    bit_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_table(input bit gapped);
    exp_t e;
    foreach (tbl[k]) begin
      for (int i = 0; i < tbl[k].nbits; i++) begin
        if (tbl[k].emit && i == tbl[k].nbits - 1) begin
          e.dat = tbl[k].dat; e.comma = tbl[k].comma;
          e.lock = tbl[k].lock; e.gap = tbl[k].gap;
          q_lsb.push_back(e);
          e.dat = rev10(tbl[k].dat);
          q_msb.push_back(e);
        end
        send_bit(tbl[k].bits[i], gapped);
      end
    end
    bit_valid = 1'b0;
    tbl.delete();
  endtask

  task automatic reset_dut();
    chk("queue_drained", 32'(q_lsb.size() + q_msb.size()), 32'd0);
    bit_valid = 1'b0;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic add_acquire();
    add(10'b0000110100, 7, 1'b0, '0, 1'b0, 1'b0, 0);
    add(C, 10, 1'b1, C, 1'b1, 1'b0, 0);
    add(N, 10, 1'b1, N, 1'b1, 1'b0, 10);
    add(C, 10, 1'b1, C, 1'b1, 1'b1, 10);
    add(D, 10, 1'b1, D, 1'b0, 1'b1, 10);
  endtask

  // One inserted bit shifts every following comma off the word boundary.
  task automatic add_slip(input bit frozen);
    add(10'd1, 1, 1'b0, '0, 1'b0, 1'b0, 0);
    add(N, 9, 1'b1, {N[8:0], 1'b1}, 1'b0, 1'b1, 10);
    add(10'(N[9]), 1, 1'b0, '0, 1'b0, 1'b0, 0);
    add(C, 9, 1'b1, {C[8:0], N[9]}, 1'b0, 1'b1, 10);
    add(10'(C[9]), 1, 1'b0, '0, 1'b0, 1'b0, 0);
    add(N, 9, 1'b1, {N[8:0], C[9]}, 1'b0, 1'b1, 10);
    add(10'(N[9]), 1, 1'b0, '0, 1'b0, 1'b0, 0);
    add(C, 9, 1'b1, {C[8:0], N[9]}, 1'b0, 1'b1, 10);
    if (!frozen) begin
      add(10'(C[9]), 1, 1'b1, C, 1'b1, 1'b0, 1);
      add(N, 10, 1'b1, N, 1'b1, 1'b0, 10);
      add(C, 10, 1'b1, C, 1'b1, 1'b1, 10);
      add(N, 10, 1'b1, N, 1'b1, 1'b1, 10);
    end else begin
      add(10'(C[9]), 1, 1'b0, '0, 1'b0, 1'b0, 0);
      add(D, 9, 1'b1, {D[8:0], C[9]}, 1'b0, 1'b1, 10);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dat_valid", 32'(dv_l), 32'd0);
    chk("reset_datout", 32'(do_l), 32'd0);
    chk("reset_is_comma", 32'(ic_l), 32'd0);
    chk("reset_locked", 32'(lk_l), 32'd0);
    chk("reset_msb_datout", 32'(do_m), 32'd0);
    reset_n = 1'b1;
    idle(2);

    // A lone comma right after reset: fill reaches WIDTH on its last bit
    add(C, 10, 1'b1, C, 1'b1, 1'b0, 0);
    run_table(1'b0);
    idle(2);
    chk("bitorder_lsb", 32'(do_l), 32'(C));
    chk("bitorder_msb", 32'(do_m), 32'(10'b0101111100));
    chk("single_comma_not_locked", 32'(lk_l), 32'd0);

    reset_dut();
    add_acquire();
    add_slip(1'b0);
    run_table(1'b0);
    idle(3);
    chk("relocked", 32'(lk_l), 32'd1);

    // Asynchronous reset in the middle of a word
    add(D, 5, 1'b0, '0, 1'b0, 1'b0, 0);
    run_table(1'b0);
    chk("queue_drained", 32'(q_lsb.size() + q_msb.size()), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("async_dat_valid", 32'(dv_l), 32'd0);
    chk("async_datout", 32'(do_l), 32'd0);
    chk("async_locked", 32'(lk_l), 32'd0);
    chk("async_is_comma", 32'(ic_l), 32'd0);
    chk("async_msb_datout", 32'(do_m), 32'd0);
    #10 reset_n = 1'b1;
    @(posedge clk); #1;
    add(D, 10, 1'b0, '0, 1'b0, 1'b0, 0);
    add(D, 10, 1'b0, '0, 1'b0, 1'b0, 0);
    run_table(1'b0);
    chk("no_word_before_comma", 32'(lk_l), 32'd0);

    // Gapped acquisition: every bit followed by an idle cycle
    add(C, 10, 1'b1, C, 1'b1, 1'b0, 0);
    add(N, 10, 1'b1, N, 1'b1, 1'b0, 20);
    add(C, 10, 1'b1, C, 1'b1, 1'b1, 20);
    add(D, 10, 1'b1, D, 1'b0, 1'b1, 20);
    run_table(1'b1);
    idle(3);

    reset_dut();
    realign_en = 1'b0;
    add_acquire();
    add_slip(1'b1);
    run_table(1'b0);
    idle(3);
    chk("frozen_locked", 32'(lk_l), 32'd1);
    chk("frozen_is_comma", 32'(ic_l), 32'd0);
    chk("queue_drained_end", 32'(q_lsb.size() + q_msb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
